mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 14 +
 rtl/mux_scan_dwell_cnt.sv | 34 +++
 rtl/mux_scan_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan controller.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: counts cycles spent on the current select; last marks the
// final dwell cycle (count == DWELL-1).
module mux_scan_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // With DWELL=1 the count never leaves zero, so last is constantly high.
  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: steps a 4:1 mux select through all channels, samples
// mux_out on each channel's final dwell cycle and publishes the 4-bit result.
// Optional macro MUX_SCAN_CONT_EN: rescan continuously after the first start.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic [NUM_CH-1:0] data,
  output logic              valid
);

  state_t            state;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] shadow_nxt;
  logic              last;
  logic              cnt_clr;
  logic              cnt_en;

  // Counter restarts on every channel change and whenever we are not scanning.
  assign cnt_en  = (state == SCAN);
  assign cnt_clr = (state != SCAN) || last;

  mux_scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (last)
  );

  // NOTE: default assignment first so no path leaves shadow_nxt unassigned
  // (which would infer a latch).
  always_comb begin
    shadow_nxt      = shadow;
    shadow_nxt[sel] = mux_out;
  end

  // data/valid load on the edge that captures channel 3, so valid is high
  // exactly while the FSM sits in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      shadow <= '0;
      data   <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            sel   <= '0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (last) begin
            shadow <= shadow_nxt;
            sel    <= sel + 1'b1;
            if (sel == SEL_W'(NUM_CH - 1)) begin
              state <= DONE;
              data  <= shadow_nxt;
              valid <= 1'b1;
            end
          end
        end
        DONE: begin
`ifdef MUX_SCAN_CONT_EN
          state <= SCAN;
          sel   <= '0;
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
